// File: rtl/vu_defs.sv
`default_nettype none
// ============================================================================
// Module   : vu_defs
// Brief    : Shared widths, FSM encodings and full-scale constants for the
//            VU peak meter.
// Revision : 1.0
// ============================================================================
package vu_defs;

    localparam int DATA_W_DEF = 8;
    localparam int LEDS_DEF   = 8;

    localparam logic ST_HOLD  = 1'b1;
    localparam logic ST_DECAY = 1'b0;

    localparam logic [DATA_W_DEF-1:0] FS_POS = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] FS_NEG = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/vu_bar_encoder.sv
`default_nettype none
// ============================================================================
// Module   : vu_bar_encoder
// Brief    : Combinational magnitude-to-thermometer encoder for the LED bar.
// Revision : 1.0
// ============================================================================
module vu_bar_encoder
    import vu_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEDS   = LEDS_DEF
) (
    input  logic [DATA_W-1:0] i_level,
    output logic [LEDS-1:0]   o_bar
);

    localparam int c_SEG = (2 ** (DATA_W - 1)) / LEDS;

    // Segment i lights once the level reaches (i+1) full segments of range.
    for (genvar i = 0; i < LEDS; i++) begin : g_seg
        localparam logic [DATA_W-1:0] c_THR = DATA_W'((i + 1) * c_SEG);
        assign o_bar[i] = (i_level >= c_THR);
    end

endmodule
`default_nettype wire

// File: rtl/vu_peak_meter.sv
`default_nettype none
// ============================================================================
// Module   : vu_peak_meter
// Brief    : Windowed peak meter with attack/hold/decay ballistics, LED bar
//            and held clip indicator, refreshed by a slow tick level.
// Revision : 1.0
// ============================================================================
module vu_peak_meter
    import vu_defs::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEDS       = LEDS_DEF,
    parameter int HOLD_TICKS = 16,
    parameter int DECAY_STEP = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              tick_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] level,
    output logic [LEDS-1:0]   bar,
    output logic              clip
);

    localparam int                c_HW     = $clog2(HOLD_TICKS + 1);
    localparam logic [c_HW-1:0]   c_HOLD   = c_HW'(HOLD_TICKS);
    localparam logic [c_HW-1:0]   c_ONE    = c_HW'(1);
    localparam logic [DATA_W:0]   c_STEP   = (DATA_W + 1)'(DECAY_STEP);
    localparam logic [DATA_W-1:0] c_FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              r_tick_d;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_level;
    logic [c_HW-1:0]   r_hold;
    logic              r_state;
    logic              r_clip;
    logic [c_HW-1:0]   r_clip_cnt;
    logic [LEDS-1:0]   r_bar;

    logic [DATA_W-1:0] w_mag;
    logic [DATA_W-1:0] w_smp;
    logic [DATA_W-1:0] w_win;
    logic [DATA_W:0]   w_floor;
    logic              w_tick_rise;
    logic              w_close;
    logic              w_clip_hit;
    logic              w_state_nxt;
    logic [DATA_W-1:0] w_level_nxt;
    logic [c_HW-1:0]   w_hold_nxt;
    logic [LEDS-1:0]   w_bar;

    // Two's complement negate of the most negative code lands exactly on
    // 2^(DATA_W-1) when read unsigned, so no extra bit is needed.
    assign w_mag       = sample[DATA_W-1] ? ((~sample) + DATA_W'(1)) : sample;
    assign w_tick_rise = tick_in & ~r_tick_d;
    assign w_close     = enable & w_tick_rise;
    assign w_smp       = sample_valid ? w_mag : '0;
    assign w_win       = (w_smp > r_acc) ? w_smp : r_acc;
    assign w_floor     = {1'b0, w_win} + c_STEP;
    assign w_clip_hit  = enable & sample_valid &
                         ((sample == c_FS_POS) | (sample == c_FS_NEG));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= ST_DECAY;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_close) begin
            if (w_win >= r_level) begin
                w_state_nxt = ST_HOLD;
            end else if ((r_state == ST_HOLD) && (r_hold <= c_ONE)) begin
                w_state_nxt = ST_DECAY;
            end
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold;
        if (w_close) begin
            if (w_win >= r_level) begin
                w_level_nxt = w_win;
                w_hold_nxt  = c_HOLD;
            end else if (r_state == ST_HOLD) begin
                if (r_hold != '0) begin
                    w_hold_nxt = r_hold - c_ONE;
                end
            end else if ({1'b0, r_level} > w_floor) begin
                w_level_nxt = r_level - c_STEP[DATA_W-1:0];
            end else begin
                w_level_nxt = w_win;
            end
        end
    end

    // The tick edge detector keeps tracking while frozen so that re-enabling
    // with the tick already high does not fabricate a refresh.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_tick_d <= 1'b0;
            r_acc    <= '0;
            r_level  <= '0;
            r_hold   <= '0;
            r_bar    <= '0;
        end else begin
            r_tick_d <= tick_in;
            if (enable) begin
                if (w_tick_rise) begin
                    r_acc <= '0;
                end else if (sample_valid && (w_mag > r_acc)) begin
                    r_acc <= w_mag;
                end
                r_level <= w_level_nxt;
                r_hold  <= w_hold_nxt;
                r_bar   <= w_bar;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_clip     <= 1'b0;
            r_clip_cnt <= '0;
        end else if (w_clip_hit) begin
            r_clip     <= 1'b1;
            r_clip_cnt <= c_HOLD;
        end else if (w_close && (r_clip_cnt != '0)) begin
            r_clip_cnt <= r_clip_cnt - c_ONE;
            if (r_clip_cnt == c_ONE) begin
                r_clip <= 1'b0;
            end
        end
    end

    vu_bar_encoder #(
        .DATA_W (DATA_W),
        .LEDS   (LEDS)
    ) u_bar_encoder (
        .i_level (r_level),
        .o_bar   (w_bar)
    );

    assign level = r_level;
    assign bar   = r_bar;
    assign clip  = r_clip;

endmodule
`default_nettype wire
